// File: rtl/mux_4_1_pkg.sv
// Shared constants for the 4-to-1 selector: select width and source codes.
package mux_4_1_pkg;

    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_I0 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_I1 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_I2 = 2'd2;
    localparam logic [SEL_W-1:0] SEL_I3 = 2'd3;

endpackage

// File: rtl/mux_4_1_if.sv
// Bus bundle for mux_4_1: select, four sources, capture qualifier and both outputs.
interface mux_4_1_if #(
    parameter int unsigned WIDTH = 1
);
    import mux_4_1_pkg::*;

    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic             in_valid;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;

    modport master (
        output sel, i0, i1, i2, i3, in_valid,
        input  y, y_q, out_valid
    );

    modport slave (
        input  sel, i0, i1, i2, i3, in_valid,
        output y, y_q, out_valid
    );

endinterface

// File: rtl/mux_4_1_sel.sv
// Combinational 4-to-1 selector; all WIDTH bits steered together by sel.
module mux_4_1_sel
    import mux_4_1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y
);

    // Unknown sel propagates as all-X in simulation; don't-care for synthesis.
    always_comb begin
        y = 'x;
        case (sel)
            SEL_I0: y = i0;
            SEL_I1: y = i1;
            SEL_I2: y = i2;
            SEL_I3: y = i3;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_4_1.sv
// 4-to-1 selector with a zero-latency output and a one-cycle registered copy with valid.
module mux_4_1 #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic       clk,
    input logic       rst,
    mux_4_1_if.slave  bus
);

    mux_4_1_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .sel (bus.sel),
        .i0  (bus.i0),
        .i1  (bus.i1),
        .i2  (bus.i2),
        .i3  (bus.i3),
        .y   (bus.y)
    );

    // Capture register: reset wins over in_valid; y_q holds when nothing is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.y_q       <= RESET_VAL;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.y_q <= bus.y;
            end
        end
    end

endmodule

// File: tb/tb_mux_4_1.sv
// Scoreboarded bench for mux_4_1: one 1-bit and one 8-bit instance on a shared clock.
module tb_mux_4_1;

    localparam int unsigned    W8      = 8;
    localparam logic [W8-1:0]  RST8    = 8'hA5;
    localparam logic [0:0]     RST1    = 1'b0;

    logic clk;
    logic rst;

    mux_4_1_if #(.WIDTH(1))  b1 ();
    mux_4_1_if #(.WIDTH(W8)) b8 ();

    mux_4_1 #(.WIDTH(1), .RESET_VAL(RST1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    mux_4_1 #(.WIDTH(W8), .RESET_VAL(RST8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [W8-1:0] q8[$];
    logic          q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pick source sel out of a list of four values.
    function automatic logic [W8-1:0] pick8(input logic [1:0] s, input logic [W8-1:0] a,
                                            input logic [W8-1:0] b, input logic [W8-1:0] c,
                                            input logic [W8-1:0] d);
        logic [W8-1:0] src[4];
        src[0] = a; src[1] = b; src[2] = c; src[3] = d;
        return src[s];
    endfunction

    function automatic logic pick1(input logic [3:0] pattern, input logic [1:0] s);
        logic [3:0] shifted;
        shifted = pattern >> s;
        return shifted[0];
    endfunction

    task automatic set1(input logic [3:0] pattern);
        b1.i0 = pattern[0]; b1.i1 = pattern[1]; b1.i2 = pattern[2]; b1.i3 = pattern[3];
    endtask

    // Predict captures for the coming edge, then advance to just after it.
    task automatic tick();
        if (!rst && b8.in_valid) q8.push_back(pick8(b8.sel, b8.i0, b8.i1, b8.i2, b8.i3));
        if (!rst && b1.in_valid) q1.push_back(pick1({b1.i3, b1.i2, b1.i1, b1.i0}, b1.sel));
        @(posedge clk);
        #2;
    endtask

    // Monitor: every presented output must match the oldest predicted capture.
    always @(negedge clk) begin
        if (b8.out_valid === 1'b1) begin
            if (q8.size() == 0) check("y_q8_unexpected", 32'(b8.y_q), 32'hFFFF_FFFF);
            else check("y_q8", 32'(b8.y_q), 32'(q8.pop_front()));
        end
        if (b1.out_valid === 1'b1) begin
            if (q1.size() == 0) check("y_q1_unexpected", 32'(b1.y_q), 32'hFFFF_FFFF);
            else check("y_q1", 32'(b1.y_q), 32'(q1.pop_front()));
        end
    end

    initial begin
        logic [1:0] s;
        logic [3:0] pat;

        rst = 1'b1;
        b1.sel = '0; b1.in_valid = 1'b0; set1(4'h0);
        b8.sel = '0; b8.in_valid = 1'b0;
        b8.i0 = '0; b8.i1 = '0; b8.i2 = '0; b8.i3 = '0;
        tick();
        tick();
        check("reset_y_q8", 32'(b8.y_q), 32'(RST8));
        check("reset_ov8", 32'(b8.out_valid), 32'd0);
        check("reset_y_q1", 32'(b1.y_q), 32'(RST1));
        check("reset_ov1", 32'(b1.out_valid), 32'd0);

        // Combinational sweeps (reset still asserted: y must not care).
        pat = 4'h5;
        set1(pat);
        for (int k = 0; k < 4; k++) begin
            b1.sel = 2'(k);
            #1;
            check("y_sweep_5", 32'(b1.y), 32'(pick1(pat, 2'(k))));
            #4;
        end
        pat = 4'hA;
        set1(pat);
        for (int k = 0; k < 4; k++) begin
            b1.sel = 2'(k);
            #1;
            check("y_sweep_A", 32'(b1.y), 32'(pick1(pat, 2'(k))));
            #4;
        end
        b1.sel = 2'd2;
        for (int k = 0; k < 4; k++) begin
            b1.i2 = ~b1.i2;
            #1;
            check("y_track_i2", 32'(b1.y), 32'(b1.i2));
            #1;
        end
        @(posedge clk);
        #2;

        // Reset priority over in_valid, then first capture after release.
        b8.i0 = 8'h11; b8.i1 = 8'h22; b8.i2 = 8'h33; b8.i3 = 8'h44;
        b8.sel = 2'd1;
        b8.in_valid = 1'b1;
        tick();
        tick();
        check("rst_prio_y_q8", 32'(b8.y_q), 32'(RST8));
        check("rst_prio_ov8", 32'(b8.out_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("release_ov8", 32'(b8.out_valid), 32'd1);

        // Back-to-back captures 3,2,1,0.
        for (int k = 3; k >= 0; k--) begin
            b8.sel = 2'(k);
            tick();
            check("b2b_ov8", 32'(b8.out_valid), 32'd1);
        end

        // Capture 8'h33, then drop in_valid: value holds, valid clears.
        b8.sel = 2'd2;
        tick();
        b8.in_valid = 1'b0;
        b8.sel = 2'd3;
        tick();
        check("hold_y_q8", 32'(b8.y_q), 32'h33);
        check("hold_ov8", 32'(b8.out_valid), 32'd0);
        tick();
        check("hold2_y_q8", 32'(b8.y_q), 32'h33);

        // Random sel on the 1-bit instance with captures every cycle.
        pat = 4'h5;
        set1(pat);
        b1.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s = 2'($urandom_range(0, 3));
            b1.sel = s;
            #1;
            check("y_rand_5", 32'(b1.y), 32'(pick1(pat, s)));
            tick();
        end
        b1.in_valid = 1'b0;

        // Random 8-bit traffic with gaps, then reset mid-stream.
        for (int k = 0; k < 12; k++) begin
            b8.i0 = 8'($urandom); b8.i1 = 8'($urandom);
            b8.i2 = 8'($urandom); b8.i3 = 8'($urandom);
            b8.sel = 2'($urandom_range(0, 3));
            b8.in_valid = 1'($urandom_range(0, 1));
            #1;
            check("y_rand8", 32'(b8.y), 32'(pick8(b8.sel, b8.i0, b8.i1, b8.i2, b8.i3)));
            tick();
        end
        b8.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        check("mid_rst_y_q8", 32'(b8.y_q), 32'(RST8));
        check("mid_rst_ov8", 32'(b8.out_valid), 32'd0);
        check("mid_rst_y8", 32'(b8.y), 32'(pick8(b8.sel, b8.i0, b8.i1, b8.i2, b8.i3)));
        rst = 1'b0;
        b8.in_valid = 1'b0;
        tick();
        tick();

        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
